// File: rtl/rob_completion_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv32_sched_pkg
//   Shared scheduler types and defaults for the ROB completion path.
//   - NUM_UNITS_DEF / ROB_ADDR_WIDTH_DEF : default sizing of the arbiter
//   - rob_idx_t                          : ROB index at the default width
//   - unit_id_t                          : execution-unit id (covers up to 8 units)
//   - wrap_idx()                         : (base + off) wrapped into 0..n-1
// ----------------------------------------------------------------------------
package rv32_sched_pkg;

    localparam int NUM_UNITS_DEF      = 4;
    localparam int ROB_ADDR_WIDTH_DEF = 5;
    localparam int MAX_UNITS          = 8;
    localparam int UNIT_ID_W          = $clog2(MAX_UNITS);

    typedef logic [ROB_ADDR_WIDTH_DEF-1:0] rob_idx_t;
    typedef logic [UNIT_ID_W-1:0]          unit_id_t;

    // base and off are both below n, so one conditional subtract is enough.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/rob_completion_arbiter_if.sv
// ----------------------------------------------------------------------------
// rob_completion_arbiter_if
//   Completion bus between the execution units, the arbiter and the ROB.
//   unit_valid     : unit i presents a completion this cycle
//   unit_rob_addr  : ROB index per unit, unit i at [i*W +: W]
//   unit_ready     : unit i's report is accepted at this edge
//   flush          : sync pulse, discard all pending reports
//   complete_instr : to ROB, mark completed_addr complete
//   completed_addr : to ROB, index being completed
//   Modports: slave = arbiter side, master = units/ROB side.
// ----------------------------------------------------------------------------
interface rob_completion_arbiter_if #(
    parameter int NUM_UNITS      = 4,
    parameter int ROB_ADDR_WIDTH = 5
);
    logic [NUM_UNITS-1:0]                unit_valid;
    logic [NUM_UNITS*ROB_ADDR_WIDTH-1:0] unit_rob_addr;
    logic [NUM_UNITS-1:0]                unit_ready;
    logic                                flush;
    logic                                complete_instr;
    logic [ROB_ADDR_WIDTH-1:0]           completed_addr;

    modport slave (
        input  unit_valid, unit_rob_addr, flush,
        output unit_ready, complete_instr, completed_addr
    );

    modport master (
        output unit_valid, unit_rob_addr, flush,
        input  unit_ready, complete_instr, completed_addr
    );
endinterface

// File: rtl/rob_completion_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer.
//   clock, reset   : clock, async active-low reset
//   req_i          : request vector
//   flush_i        : suppress any grant this cycle and return pointer to 0
//   grant_o        : one-hot grant, first request at/after the pointer
//   grant_valid_o  : some request was granted
//   grant_idx_o    : binary index of the granted requester
// ----------------------------------------------------------------------------
module rr_arbiter
    import rv32_sched_pkg::*;
#(
    parameter  int NUM_UNITS = NUM_UNITS_DEF,
    localparam int IDX_W     = $clog2(NUM_UNITS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_UNITS-1:0] req_i,
    input  logic                 flush_i,
    output logic [NUM_UNITS-1:0] grant_o,
    output logic                 grant_valid_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand_idx;

    // NOTE: every output of a combinational block is given a default before
    // any branch, so no path leaves a value unassigned and no latch appears.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand_idx      = '0;
        if (!flush_i) begin
            for (int off = 0; off < NUM_UNITS; off++) begin
                cand_idx = IDX_W'(wrap_idx(int'(ptr_q), off, NUM_UNITS));
                if (!grant_valid_o && req_i[cand_idx]) begin
                    grant_valid_o     = 1'b1;
                    grant_idx_o       = cand_idx;
                    grant_o[cand_idx] = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (grant_valid_o) begin
            ptr_d = IDX_W'(wrap_idx(int'(grant_idx_o), 1, NUM_UNITS));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rob_completion_arbiter.sv
// ----------------------------------------------------------------------------
// rob_completion_arbiter
//   Funnels completion reports from NUM_UNITS execution units into the ROB's
//   single completion port. Each unit owns a 1-entry holding buffer; a
//   round-robin arbiter grants one buffered report per cycle and the granted
//   ROB index is driven to the ROB from a register.
//
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   bus     : rob_completion_arbiter_if.slave (unit handshake + ROB port)
//   stall_cnt (COMPL_ARB_PERF_CNT_EN only): NUM_UNITS x 16-bit saturating
//             counts of cycles with unit_valid[i] && !unit_ready[i];
//             cleared by reset only.
//
//   Optional feature macro: COMPL_ARB_PERF_CNT_EN
// ----------------------------------------------------------------------------
module rob_completion_arbiter
    import rv32_sched_pkg::*;
#(
    parameter int NUM_UNITS      = NUM_UNITS_DEF,
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    rob_completion_arbiter_if.slave   bus
`ifdef COMPL_ARB_PERF_CNT_EN
    ,
    output logic [NUM_UNITS*16-1:0]   stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]      buf_valid_q, buf_valid_d;
    logic [ROB_ADDR_WIDTH-1:0] buf_addr_q [NUM_UNITS];
    logic [ROB_ADDR_WIDTH-1:0] buf_addr_d [NUM_UNITS];

    logic                      complete_instr_q, complete_instr_d;
    logic [ROB_ADDR_WIDTH-1:0] completed_addr_q, completed_addr_d;

    logic [NUM_UNITS-1:0]      grant;
    logic                      grant_valid;
    logic [IDX_W-1:0]          grant_idx;
    logic [NUM_UNITS-1:0]      unit_ready;
    logic [NUM_UNITS-1:0]      accept;

    rr_arbiter #(
        .NUM_UNITS (NUM_UNITS)
    ) u_rr_arbiter (
        .clock         (clock),
        .reset         (reset),
        .req_i         (buf_valid_q),
        .flush_i       (bus.flush),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // A slot can take a new report when empty or when its current report is
    // leaving this edge. Depends only on state and flush, never on unit_valid.
    assign unit_ready     = {NUM_UNITS{~bus.flush}} & (~buf_valid_q | grant);
    assign accept         = bus.unit_valid & unit_ready;
    assign bus.unit_ready = unit_ready;

    // Holding buffers: a same-edge accept overrides the grant's clear.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (bus.flush) begin
                buf_valid_d[i] = 1'b0;
            end else if (accept[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_addr_d[i]  = bus.unit_rob_addr[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
    end

    // Grant is already suppressed during flush, so complete_instr drops there.
    always_comb begin
        complete_instr_d = grant_valid;
        completed_addr_d = completed_addr_q;
        if (grant_valid) begin
            completed_addr_d = buf_addr_q[grant_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_q      <= '0;
            complete_instr_q <= 1'b0;
            completed_addr_q <= '0;
        end else begin
            buf_valid_q      <= buf_valid_d;
            complete_instr_q <= complete_instr_d;
            completed_addr_q <= completed_addr_d;
        end
    end

    // NOTE: payload storage is not reset; buf_valid_q qualifies every read,
    // so stale contents after reset are never observed.
    always_ff @(posedge clock) begin
        buf_addr_q <= buf_addr_d;
    end

    assign bus.complete_instr = complete_instr_q;
    assign bus.completed_addr = completed_addr_q;

`ifdef COMPL_ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q [NUM_UNITS];

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (bus.unit_valid[i] && !unit_ready[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
                    stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            stall_cnt[i*16 +: 16] = stall_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rob_completion_arbiter
//   Self-checking bench for rob_completion_arbiter (4 units, 5-bit indices).
//   Directed table, hand-written flush/reset sequences, then random traffic
//   compared against a cycle-level behavioural model of the completion rules.
//   The stall-counter checks are built only with COMPL_ARB_PERF_CNT_EN.
// ----------------------------------------------------------------------------
module tb_rob_completion_arbiter;
    import rv32_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 5;

    logic clock;
    logic reset;

    rob_completion_arbiter_if #(.NUM_UNITS(N), .ROB_ADDR_WIDTH(W)) bus ();

`ifdef COMPL_ARB_PERF_CNT_EN
    logic [N*16-1:0] stall_cnt;
`endif

    rob_completion_arbiter #(
        .NUM_UNITS      (N),
        .ROB_ADDR_WIDTH (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus)
`ifdef COMPL_ARB_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_pend [N];
    rob_idx_t m_addr [N];
    int       m_ptr;
    bit       m_cv;
    rob_idx_t m_ca;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr = 0;
        m_cv  = 1'b0;
        m_ca  = '0;
    endfunction

    // Which waiting unit wins this cycle (-1 if none).
    function automatic int model_winner(input bit f);
        int w;
        w = -1;
        if (!f) begin
            for (int k = 0; k < N; k++) begin
                int u;
                u = (m_ptr + k) % N;
                if (w < 0 && m_pend[u]) w = u;
            end
        end
        return w;
    endfunction

    function automatic logic [N-1:0] model_ready(input bit f);
        logic [N-1:0] r;
        int w;
        w = model_winner(f);
        for (int i = 0; i < N; i++) r[i] = !f && (!m_pend[i] || (w == i));
        return r;
    endfunction

    function automatic void model_step(input logic [N-1:0] v, input logic [N*W-1:0] a, input bit f);
        logic [N-1:0] r;
        int w;
        r = model_ready(f);
        w = model_winner(f);
        if (f) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr = 0;
            m_cv  = 1'b0;
        end else if (w >= 0) begin
            m_cv      = 1'b1;
            m_ca      = m_addr[w];
            m_pend[w] = 1'b0;
            m_ptr     = (w + 1) % N;
        end else begin
            m_cv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && r[i]) begin
                m_pend[i] = 1'b1;
                m_addr[i] = a[i*W +: W];
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] a, input bit f);
        @(negedge clock);
        bus.unit_valid    = v;
        bus.unit_rob_addr = a;
        bus.flush         = f;
        #1;
    endtask

    task automatic mcycle(input string tag, input logic [N-1:0] v, input logic [N*W-1:0] a, input bit f);
        drive(v, a, f);
        check({tag, "_ci"},  32'(bus.complete_instr), 32'(m_cv));
        check({tag, "_ca"},  32'(bus.completed_addr), 32'(m_ca));
        check({tag, "_rdy"}, 32'(bus.unit_ready),     32'(model_ready(f)));
        model_step(v, a, f);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset             = 1'b0;
        bus.unit_valid    = '0;
        bus.unit_rob_addr = '0;
        bus.flush         = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] a;
        bit             f;
        bit             ci;
        logic [W-1:0]   ca;
        logic [N-1:0]   rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(input logic [N-1:0] v, input logic [N*W-1:0] a, input bit f,
                                 input bit ci, input int ca, input logic [N-1:0] rdy);
        vec_t r;
        r.v = v; r.a = a; r.f = f; r.ci = ci; r.ca = W'(ca); r.rdy = rdy;
        return r;
    endfunction

    initial begin
        logic [N-1:0]   rv;
        logic [N*W-1:0] ra;
        bit             rf;

        reset             = 1'b0;
        bus.unit_valid    = '0;
        bus.unit_rob_addr = '0;
        bus.flush         = 1'b0;
        model_reset();

        // single report, 4-wide burst, unit-2 stream
        vecs.push_back(row(4'b0001, pack4(5,0,0,0), 0, 0, 0, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 0, 0, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 1, 5, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 0, 5, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             1, 0, 5, 4'b0000));
        vecs.push_back(row(4'b1111, pack4(1,2,3,4), 0, 0, 5, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 0, 5, 4'b0001));
        vecs.push_back(row(4'b0000, '0,             0, 1, 1, 4'b0011));
        vecs.push_back(row(4'b0000, '0,             0, 1, 2, 4'b0111));
        vecs.push_back(row(4'b0000, '0,             0, 1, 3, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 1, 4, 4'b1111));
        vecs.push_back(row(4'b0100, pack4(0,0,7,0), 0, 0, 4, 4'b1111));
        vecs.push_back(row(4'b0100, pack4(0,0,8,0), 0, 0, 4, 4'b1111));
        vecs.push_back(row(4'b0100, pack4(0,0,9,0), 0, 1, 7, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 1, 8, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 1, 9, 4'b1111));
        vecs.push_back(row(4'b0000, '0,             0, 0, 9, 4'b1111));

        do_reset();
        #1;
        check("reset_ci",  32'(bus.complete_instr), 32'd0);
        check("reset_ca",  32'(bus.completed_addr), 32'd0);
        check("reset_rdy", 32'(bus.unit_ready),     32'hF);

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].a, vecs[k].f);
            check($sformatf("vec%0d_ci", k),  32'(bus.complete_instr), 32'(vecs[k].ci));
            check($sformatf("vec%0d_ca", k),  32'(bus.completed_addr), 32'(vecs[k].ca));
            check($sformatf("vec%0d_rdy", k), 32'(bus.unit_ready),     32'(vecs[k].rdy));
            model_step(vecs[k].v, vecs[k].a, vecs[k].f);
        end

        // ---- flush with units 1 and 3 buffered; pointer was left at 3 ----
        mcycle("fl_load", 4'b1010, pack4(0,10,0,11), 0);
        drive('0, '0, 1);
        check("fl_rdy", 32'(bus.unit_ready), 32'd0);
        model_step('0, '0, 1);
        for (int k = 0; k < 5; k++) begin
            drive('0, '0, 0);
            check($sformatf("fl_ci%0d", k), 32'(bus.complete_instr), 32'd0);
            check($sformatf("fl_ca%0d", k), 32'(bus.completed_addr), 32'd9);
            model_step('0, '0, 0);
        end
        // pointer back at 0: unit 0 must beat unit 3
        mcycle("fl_ptr_a", 4'b1001, pack4(21,0,0,20), 0);
        mcycle("fl_ptr_b", 4'b0000, '0, 0);
        drive('0, '0, 0);
        check("fl_ptr_ci", 32'(bus.complete_instr), 32'd1);
        check("fl_ptr_ca", 32'(bus.completed_addr), 32'd21);
        model_step('0, '0, 0);
        mcycle("fl_ptr_c", 4'b0000, '0, 0);

        // ---- async reset between edges with buffers full ----
        mcycle("ar_load", 4'b1111, pack4(12,13,14,15), 0);
        mcycle("ar_g0",   4'b0000, '0, 0);
        @(posedge clock);
        #2;
        check("ar_pre_ci", 32'(bus.complete_instr), 32'd1);
        reset = 1'b0;
        #1;
        check("ar_ci", 32'(bus.complete_instr), 32'd0);
        check("ar_ca", 32'(bus.completed_addr), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) mcycle($sformatf("ar_post%0d", k), '0, '0, 0);

        // ---- random traffic against the model ----
        for (int k = 0; k < 400; k++) begin
            rv = N'($urandom);
            ra = (N*W)'($urandom);
            rf = ($urandom_range(0, 19) == 0);
            mcycle($sformatf("rnd%0d", k), rv, ra, rf);
        end

`ifdef COMPL_ARB_PERF_CNT_EN
        // ---- stall counters: unit 1 blocked by flush every cycle ----
        do_reset();
        repeat (5) drive(4'b0010, pack4(0,3,0,0), 1);
        drive('0, '0, 0);
        check("perf_cnt1_5", 32'(stall_cnt[16 +: 16]), 32'd5);
        check("perf_cnt0_0", 32'(stall_cnt[0 +: 16]),  32'd0);
        repeat (65535) drive(4'b0010, pack4(0,3,0,0), 1);
        drive('0, '0, 0);
        check("perf_cnt1_sat", 32'(stall_cnt[16 +: 16]), 32'hFFFF);
        check("perf_cnt2_0",   32'(stall_cnt[32 +: 16]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
